// File: rtl/data_mem_lsu.sv
// data_mem_lsu: multi-cycle load/store unit turning core memory requests into handshaked word bus transactions.
// Optional macro DATA_MEM_MISALIGN_EN makes misaligned half/word accesses legal, splitting word-crossing ones in two.
module data_mem_lsu #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        mem_wren_i,
  input  logic [1:0]  mem_mode_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        wren_q, wren_d;
  logic [1:0]  mode_q, mode_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] rd0_q, rd0_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic [1:0]  req_off_s;
  logic [3:0]  be_base_s;
  logic [7:0]  be_full_s;
  logic [63:0] wdata_full_s;
  logic        illegal_s;
  logic        split_req_s;

  function automatic logic [31:0] load_extend(input logic [1:0] mode, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rd1,
                                              input logic [31:0] rd0);
    logic [63:0] shifted;
    logic [31:0] raw;
    logic [31:0] res;
    shifted = {rd1, rd0} >> {off, 3'b000};
    raw = shifted[31:0];
    case (mode)
      2'b00:   res = uns ? {24'h00_0000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res = uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      2'b10:   res = raw;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Request decode: lane enables and lane-shifted data over a two-word window, legality, split need
  always_comb begin
    req_off_s = addr_i[1:0];
    case (mem_mode_i)
      2'b00:   be_base_s = 4'b0001;
      2'b01:   be_base_s = 4'b0011;
      2'b10:   be_base_s = 4'b1111;
      default: be_base_s = 4'b0000;
    endcase
    be_full_s    = {4'b0000, be_base_s} << req_off_s;
    wdata_full_s = {32'h0000_0000, wdata_i} << {req_off_s, 3'b000};
`ifdef DATA_MEM_MISALIGN_EN
    illegal_s   = (mem_mode_i == 2'b11);
    split_req_s = ((mem_mode_i == 2'b01) && (req_off_s == 2'b11)) ||
                  ((mem_mode_i == 2'b10) && (req_off_s != 2'b00));
`else
    illegal_s   = (mem_mode_i == 2'b11) ||
                  ((mem_mode_i == 2'b01) && req_off_s[0]) ||
                  ((mem_mode_i == 2'b10) && (req_off_s != 2'b00));
    split_req_s = 1'b0;
`endif
  end

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d     = state_q;
    wren_d      = wren_q;
    mode_d      = mode_q;
    uns_d       = uns_q;
    off_d       = off_q;
    split_d     = split_q;
    be_hi_d     = be_hi_q;
    wdata_hi_d  = wdata_hi_q;
    rd0_d       = rd0_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (ready_q && req_valid_i) begin
          wren_d     = mem_wren_i;
          mode_d     = mem_mode_i;
          uns_d      = mem_unsigned_i;
          off_d      = req_off_s;
          split_d    = split_req_s;
          be_hi_d    = be_full_s[7:4];
          wdata_hi_d = wdata_full_s[63:32];
          rd0_d      = 32'h0000_0000;
          ready_d    = 1'b0;
          if (illegal_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 32'h0000_0000;
          end else begin
            state_d     = ACC0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wren_i;
            bus_addr_d  = {addr_i[31:2], 2'b00};
            bus_be_d    = be_full_s[3:0];
            bus_wdata_d = wdata_full_s[31:0];
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ACC0: begin
        if (bus_ack_i) begin
          if (split_q) begin
            state_d     = ACC1;
            rd0_d       = bus_rdata_i;
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_be_d    = be_hi_q;
            bus_wdata_d = wdata_hi_q;
          end else begin
            state_d     = RESP;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = RESET_ADDR;
            bus_be_d    = 4'b0000;
            bus_wdata_d = 32'h0000_0000;
            rsp_valid_d = 1'b1;
            err_d       = 1'b0;
            rdata_d     = wren_q ? 32'h0000_0000
                                 : load_extend(mode_q, uns_q, off_q, 32'h0000_0000, bus_rdata_i);
          end
        end else begin
          state_d = ACC0;
        end
      end
      ACC1: begin
        if (bus_ack_i) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = RESET_ADDR;
          bus_be_d    = 4'b0000;
          bus_wdata_d = 32'h0000_0000;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = wren_q ? 32'h0000_0000
                               : load_extend(mode_q, uns_q, off_q, bus_rdata_i, rd0_q);
        end else begin
          state_d = ACC1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        rdata_d     = 32'h0000_0000;
      end
      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        rdata_d     = 32'h0000_0000;
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = RESET_ADDR;
        bus_be_d    = 4'b0000;
        bus_wdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wren_q      <= 1'b0;
      mode_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      split_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0000_0000;
      rd0_q       <= 32'h0000_0000;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= RESET_ADDR;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      mode_q      <= mode_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      split_q     <= split_d;
      be_hi_q     <= be_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      rd0_q       <= rd0_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: vector table with a response/bus scoreboard plus reset and idle-ack sequences.
module tb_data_mem_lsu;
  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        mem_wren_i;
  logic [1:0]  mem_mode_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  data_mem_lsu #(.RESET_ADDR(RST_ADDR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .mem_wren_i(mem_wren_i), .mem_mode_i(mem_mode_i), .mem_unsigned_i(mem_unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o),
    .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wren;  logic [1:0] mode; logic uns; logic [31:0] addr; logic [31:0] wdata;
    int          waits; logic [31:0] rd0; logic [31:0] rd1;
    logic        err;   logic [31:0] rdata; int nacc;
    logic [31:0] a0;    logic [3:0] be0;  logic [31:0] wd0;
    logic [31:0] a1;    logic [3:0] be1;  logic [31:0] wd1;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
  typedef struct { logic err; logic [31:0] rdata; int lat; } rsp_t;

  vec_t vecs[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic run_vec(input vec_t v);
    int   k;
    int   acc;
    int   wcnt;
    bit   in_acc;
    bit   done;
    bus_t cur;
    bus_t snap;
    bus_t eb;
    rsp_t er;
    logic [31:0] m;
    rsp_q.push_back(rsp_t'{v.err, v.rdata, 1 + v.nacc * (v.waits + 1)});
    if (v.nacc > 0) bus_q.push_back(bus_t'{v.a0, v.be0, v.wren, v.wd0});
    if (v.nacc > 1) bus_q.push_back(bus_t'{v.a1, v.be1, v.wren, v.wd1});
    chk("ready_idle", req_ready_o, 1);
    mem_wren_i = v.wren; mem_mode_i = v.mode; mem_unsigned_i = v.uns;
    addr_i = v.addr; wdata_i = v.wdata; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 1; acc = 0; wcnt = 0; in_acc = 1'b0; done = 1'b0;
    snap = bus_t'{32'h0, 4'h0, 1'b0, 32'h0};
    while (!done && k < 40) begin
      bus_ack_i = 1'b0;
      if (rsp_valid_o) begin
        chk("ready_in_resp", req_ready_o, 0);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid_o, 0);
        end else begin
          er = rsp_q.pop_front();
          chk("rsp_err", err_o, er.err);
          chk("rsp_rdata", rdata_o, er.rdata);
          chk("rsp_latency", k, er.lat);
        end
        done = 1'b1;
      end else begin
        chk("ready_busy", req_ready_o, 0);
        if (bus_req_o) begin
          cur = bus_t'{bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o};
          if (!in_acc) begin
            if (bus_q.size() == 0) begin
              chk("bus_unexpected", bus_req_o, 0);
            end else begin
              eb = bus_q.pop_front();
              m = lane_mask(eb.be);
              chk("bus_addr", bus_addr_o, eb.addr);
              chk("bus_be", bus_be_o, eb.be);
              chk("bus_we", bus_we_o, eb.we);
              if (eb.we) chk("bus_wdata", bus_wdata_o & m, eb.wdata & m);
              chk("acc_start", k, 1 + acc * (v.waits + 1));
            end
            snap = cur; in_acc = 1'b1; wcnt = 0;
          end else begin
            chk("bus_stable", {cur.addr, cur.be, cur.we, cur.wdata},
                {snap.addr, snap.be, snap.we, snap.wdata});
          end
          if (wcnt == v.waits) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = (acc == 0) ? v.rd0 : v.rd1;
            in_acc = 1'b0;
            acc++;
          end else begin
            wcnt++;
            bus_rdata_i = 32'h5A5A_5A5A;
          end
        end else begin
          bus_rdata_i = 32'hA5A5_A5A5;
        end
      end
      if (!done) begin
        @(negedge clk_i);
        k++;
      end
    end
    if (!done) chk("rsp_timeout", rsp_valid_o, 1);
    chk("acc_count", acc, v.nacc);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("rsp_one_cycle", rsp_valid_o, 0);
    chk("ready_after", req_ready_o, 1);
    chk("bus_idle_req", bus_req_o, 0);
    chk("bus_idle_addr", bus_addr_o, RST_ADDR);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; mem_wren_i = 1'b0; mem_mode_i = 2'b00;
    mem_unsigned_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

    //                wren  mode   uns  addr           wdata         w  rd0            rd1            err  rdata          n  a0             be0      wd0            a1             be1      wd1
    vecs.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0,         1'b0, 32'hFFFF_FF80, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0,         1'b0, 32'h0000_0080, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h0000_0200, 4'b1100, 32'hABCD_0000, 32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        0, 32'h8001_7FFF, 32'h0,         1'b0, 32'hFFFF_8001, 1, 32'h0000_0010, 4'b1100, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        2, 32'h1234_F00D, 32'h0,         1'b0, 32'h0000_F00D, 1, 32'h0000_0010, 4'b0011, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0,        1, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF, 1, 32'h0000_0020, 4'b1111, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 0, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h0000_0024, 4'b1111, 32'hCAFE_F00D, 32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'hFFFF_FFA5, 0, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h0000_0030, 4'b0010, 32'h0000_A500, 32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,        0, 32'h1111_117F, 32'h0,         1'b0, 32'h0000_007F, 1, 32'h0000_0000, 4'b0001, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b11, 1'b0, 32'h0000_0044, 32'h7777_7777, 0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
`ifdef DATA_MEM_MISALIGN_EN
    vecs.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,        0, 32'hBEEF_1234, 32'h5678_CAFE, 1'b0, 32'hCAFE_BEEF, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0,         32'h0000_0000, 4'b0011, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h0000_0003, 32'h1122_3344, 1, 32'h0,        32'h0,         1'b0, 32'h0,         2, 32'h0000_0000, 4'b1000, 32'h4400_0000, 32'h0000_0004, 4'b0111, 32'h0011_2233});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        0, 32'h00AB_CD00, 32'h0,         1'b0, 32'hFFFF_ABCD, 1, 32'h0000_0200, 4'b0110, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        2, 32'h3322_1100, 32'h7766_5544, 1'b0, 32'h4433_2211, 2, 32'h0000_0100, 4'b1110, 32'h0,         32'h0000_0104, 4'b0001, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'h0,        0, 32'hAB00_0000, 32'h0000_00CD, 1'b0, 32'h0000_CDAB, 2, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_0204, 4'b0001, 32'h0});
`else
    vecs.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_5678, 0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0});
`endif

    // Two reset edges, then every output is zero and the bus address is parked
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_bus_addr", bus_addr_o, RST_ADDR);
    chk("rst_bus_be", bus_be_o, 0);
    chk("rst_bus_we", bus_we_o, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", req_ready_o, 1);

    // Ack with no request outstanding must be ignored
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk_i);
      chk("idle_ack_req", bus_req_o, 0);
      chk("idle_ack_rsp", rsp_valid_o, 0);
    end
    bus_ack_i = 1'b0;
    chk("idle_ack_ready", req_ready_o, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset held two cycles while ACC0 waits for ack abandons the access
    mem_wren_i = 1'b0; mem_mode_i = 2'b10; mem_unsigned_i = 1'b0;
    addr_i = 32'h0000_0020; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("acc0_req_before_rst", bus_req_o, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_bus_req", bus_req_o, 0);
    chk("midrst_rsp", rsp_valid_o, 0);
    @(negedge clk_i);
    chk("midrst_rsp2", rsp_valid_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready", req_ready_o, 1);
    chk("midrst_bus_req_after", bus_req_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("midrst_no_rsp", rsp_valid_o, 0);
    end
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

- Multi-cycle load/store unit that accepts decoded memory requests from the core and executes them as handshaked word transactions on a 32-bit data bus.
- Request fields are width (`mem_mode`), write enable (`mem_wren`), signedness (`mem_unsigned`), address and store data.
- Sits between the execute stage (ALU address result, `mem_mode`/`mem_wren`/`mem_unsigned` from the control unit) and data memory. Returns sign- or zero-extended load data for writeback.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, value driven on bus_addr_o while idle/reset

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  unit can accept a request
- mem_wren_i  in  1  1 = store, 0 = load
- mem_mode_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_unsigned_i  in  1  zero-extend load (ignored for word, stores)
- addr_i  in  32  byte address
- wdata_i  in  32  store data, LSBs significant
- rsp_valid_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data; 0 for stores/errors
- err_o  out  1  valid with rsp_valid_o; access rejected
- bus_req_o  out  1  bus transaction request, held until ack
- bus_we_o  out  1  write transaction
- bus_addr_o  out  32  word-aligned address (bits[1:0]=00)
- bus_be_o  out  4  byte enables, lane i = bits[8i+7:8i]
- bus_wdata_o  out  32  lane-shifted store data
- bus_ack_i  in  1  transaction complete; bus_rdata_i valid same cycle
- bus_rdata_i  in  32  read data

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields; off = addr_i[1:0].
  - Illegal request: mode 11, or misaligned (half with off[0]=1, word with off≠0) when the feature is out. Go to RESP with err_o=1 and no bus activity.
  - Otherwise go to ACC0.
- ACC0:
  - bus_req_o=1, bus_addr_o = {addr[31:2],2'b00}.
  - bus_be_o: byte 0001<<off, half 0011<<off, word 1111 (low lanes only if split).
  - bus_wdata_o = wdata << 8*off.
  - On bus_ack_i: capture bus_rdata_i; go to ACC1 if split needed, else RESP.
- ACC1 (split only):
  - Address = first word address + 4, 32-bit wrap (FFFF_FFFC → 0000_0000).
  - be = remaining upper-overflow lanes.
  - wdata = wdata >> 8*(4-off).
  - On ack → RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - Loads: raw = {rd1,rd0} >> 8*off; byte/half sign-extended unless mem_unsigned; word passes through.
- Bus handshake:
  - bus_req_o and all bus_* stay stable until the cycle bus_ack_i is high.
  - bus_ack_i while bus_req_o=0 is ignored.
  - Deassert for at least one cycle between ACC0 and ACC1 is not required; ACC1 asserts the cycle after the ACC0 ack.
- Reset: all outputs 0 (bus_addr_o = RESET_ADDR), state IDLE. Reset mid-transaction abandons it: bus_req_o low after the edge, no rsp_valid_o.

## Timing
- Accept at cycle N → bus_req_o at N+1.
- Ack at cycle M → rsp_valid_o at M+1 (single access) or bus_req_o for ACC1 at M+1.
- Minimum latency, zero-wait bus: 2 cycles accept-to-response; 3 for split.
- Error response: rsp_valid_o at N+1.
- req_ready_o=0 in ACC0/ACC1/RESP. A new request can be accepted the cycle after RESP (no back-to-back in RESP).

## Configuration
- DATA_MEM_MISALIGN_EN defined:
  - Misaligned half/word accesses are legal.
  - Accesses fitting in one word (half off=1, 2) use one transaction.
  - Word-crossing accesses (half off=3, word off=1..3) split into ACC0+ACC1.
- Undefined: any misaligned half/word → err_o=1, no bus transaction; ACC1 unreachable.

## Test plan
- Reset held 2 cycles mid-ACC0 (bus_req_o=1) → bus_req_o=0, req_ready_o=1, rsp_valid_o never pulses.
- lb addr 0x103, bus_rdata 0x80FF_0000, ack 0-wait → bus_be 1000, rdata_o 0xFFFF_FF80, rsp_valid_o 2 cycles after accept; lbu same → 0x0000_0080.
- sh addr 0x202 data 0x1234_ABCD, ack after 3 waits → bus_we 1, be 1100, wdata 0xABCD_xxxx (lanes 3:2 = ABCD), bus signals stable during waits.
- lw addr 0x101, macro undefined → err_o=1, rdata_o 0, no bus_req_o; mode 11 → err_o=1 in both builds.
- Macro defined: lw addr 0xFFFF_FFFE, rd0 0xBEEF_xxxx, rd1 0xxxxx_CAFE → addresses FFFF_FFFC then 0000_0000, be 1100 then 0011, rdata_o 0xCAFE_BEEF.
- Macro defined: sw addr 0x0003 data 0x1122_3344 → be 1000 wdata 0x44xx_xxxx at 0x0, then be 0111 wdata 0xxx11_2233 at 0x4.
